mdl: RTL and testbench

mdl is a small word store with in-place arithmetic: DEPTH words of WIDTH bits, addressed by a command interface. Each command is an opcode plus address and data, and the block can shift, increment, load, clear or read a word. It sits as a leaf datapath block under a sequencing controller that issues one command at a time over a valid/ready handshake.

---
 rtl/mdl_if.sv | 39 +++
 rtl/mdl.sv | 151 +++++++++++++++
 tb/tb_mdl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mdl_if.sv
// Command/response interface for the mdl word store.
// Optional zero flag present when MDL_ZERO_FLAG_EN is defined.
`default_nettype none

interface mdl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             err;
  logic             carry;
`ifdef MDL_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
`ifdef MDL_ZERO_FLAG_EN
    input  zero,
`endif
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rdata, rvalid, err, carry
  );

  modport slave (
`ifdef MDL_ZERO_FLAG_EN
    output zero,
`endif
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rdata, rvalid, err, carry
  );
endinterface

`default_nettype wire

// File: rtl/mdl.sv
// ---------------------------------------------------------------------------
// Module : mdl
// Brief  : DEPTH x WIDTH word store with in-place SHR2/SHL1/INC, LOAD, CLR,
//          READ over a valid/ready command interface. Optional feature macro:
//          MDL_ZERO_FLAG_EN (adds registered zero flag updated on READ).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mdl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic clk,
  input  logic rst_n,
  mdl_if.slave bus_if
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHR2 = 3'b001;
  localparam logic [2:0] OP_SHL1 = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_READ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             ready_q;
  logic             rvalid_q;
  logic             err_q;
  logic             carry_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] opnd_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    addr_q;
`ifdef MDL_ZERO_FLAG_EN
  logic             zero_q;
`endif

  logic             accept;
  logic             addr_ok;
  logic             illegal;
  logic [WIDTH-1:0] wb_result_d;
  logic             wb_carry_d;

  assign accept  = bus_if.cmd_valid & ready_q;
  // One extra bit so DEPTH == 2**AW still compares correctly.
  assign addr_ok = ({1'b0, bus_if.cmd_addr} < (AW+1)'(DEPTH));
  assign illegal = (bus_if.cmd_op == OP_RSVD) ||
                   (!addr_ok && (bus_if.cmd_op != OP_NOP) && (bus_if.cmd_op != OP_CLR));

  always_comb begin
    wb_result_d = opnd_q;
    wb_carry_d  = 1'b0;
    case (op_q)
      OP_SHR2: wb_result_d = opnd_q >> 2;
      OP_SHL1: begin
        wb_result_d = opnd_q << 1;
        wb_carry_d  = opnd_q[WIDTH-1];
      end
      OP_INC: begin
        wb_result_d = opnd_q + WIDTH'(1);
        wb_carry_d  = &opnd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
      rdata_q  <= '0;
      opnd_q   <= '0;
      op_q     <= OP_NOP;
      addr_q   <= '0;
`ifdef MDL_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              case (bus_if.cmd_op)
                OP_LOAD: mem_q[bus_if.cmd_addr] <= bus_if.cmd_wdata;
                OP_CLR: begin
                  for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                  carry_q <= 1'b0;
                end
                OP_READ: begin
                  rdata_q  <= mem_q[bus_if.cmd_addr];
                  rvalid_q <= 1'b1;
`ifdef MDL_ZERO_FLAG_EN
                  zero_q   <= (mem_q[bus_if.cmd_addr] == '0);
`endif
                end
                OP_SHR2, OP_SHL1, OP_INC: begin
                  opnd_q  <= mem_q[bus_if.cmd_addr];
                  op_q    <= bus_if.cmd_op;
                  addr_q  <= bus_if.cmd_addr;
                  state_q <= ST_WB;
                  ready_q <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_WB: begin
          mem_q[addr_q] <= wb_result_d;
          if (wb_carry_d) carry_q <= 1'b1;
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_if.cmd_ready = ready_q;
  assign bus_if.rdata     = rdata_q;
  assign bus_if.rvalid    = rvalid_q;
  assign bus_if.err       = err_q;
  assign bus_if.carry     = carry_q;
`ifdef MDL_ZERO_FLAG_EN
  assign bus_if.zero      = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdl.sv
// Scoreboard bench for mdl: driver feeds an arithmetic reference model that
// queues expected pulses; a negedge monitor pops and compares them.
`default_nettype none

module tb_mdl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int MODV  = 2 ** WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  mdl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus)
  );

  typedef struct {
    bit is_err;
    int data;
    bit carry;
    bit zero;
  } exp_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   words[DEPTH];
  bit   m_carry;
  exp_t expq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) words[i] = 0;
    m_carry = 1'b0;
    expq.delete();
  endfunction

  // Reference behaviour from the opcode rules using plain integer arithmetic.
  function automatic void model_apply(input int op, input int addr, input int d);
    exp_t e;
    e.is_err = 1'b0; e.data = 0; e.carry = 1'b0; e.zero = 1'b0;
    if (op == 7 || (op != 0 && op != 4 && addr >= DEPTH)) begin
      e.is_err = 1'b1;
      expq.push_back(e);
      return;
    end
    case (op)
      1: words[addr] = words[addr] / 4;
      2: begin
        if (words[addr] >= MODV / 2) m_carry = 1'b1;
        words[addr] = (words[addr] * 2) % MODV;
      end
      3: words[addr] = d % MODV;
      4: begin
        for (int i = 0; i < DEPTH; i++) words[i] = 0;
        m_carry = 1'b0;
      end
      5: begin
        if (words[addr] == MODV - 1) m_carry = 1'b1;
        words[addr] = (words[addr] + 1) % MODV;
      end
      6: begin
        e.data  = words[addr];
        e.carry = m_carry;
        e.zero  = (words[addr] == 0);
        expq.push_back(e);
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic issue(input int op, input int addr, input int d);
    int   guard = 0;
    logic [31:0] opv, addrv, dv;
    opv = op; addrv = addr; dv = d;
    while (bus.cmd_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", bus.cmd_ready, 1);
    if (bus.cmd_ready !== 1'b1) return;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = opv[2:0];
    bus.cmd_addr  = addrv[AW-1:0];
    bus.cmd_wdata = dv[WIDTH-1:0];
    model_apply(op, addr, d);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if ((op == 1 || op == 2 || op == 5) && addr < DEPTH) begin
      check("ready_low_after_rmw", bus.cmd_ready, 0);
      // A clear presented while busy must be ignored.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'b100;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("ready_back_after_wb", bus.cmd_ready, 1);
    end else begin
      check("ready_stays_high", bus.cmd_ready, 1);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.rvalid === 1'b1 && bus.err === 1'b1) begin
        check("rvalid_err_exclusive", 1, 0);
      end else if (bus.rvalid === 1'b1 || bus.err === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", bus.err === 1'b1 ? 2 : 1, 0);
        end else begin
          e = expq.pop_front();
          check("pulse_is_err", bus.err, e.is_err);
          if (!e.is_err && bus.rvalid === 1'b1) begin
            check("rdata", bus.rdata, e.data);
            check("carry_at_read", bus.carry, e.carry);
`ifdef MDL_ZERO_FLAG_EN
            check("zero_at_read", bus.zero, e.zero);
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, addr;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready",  bus.cmd_ready, 1);
    check("reset_rdata",  bus.rdata, 0);
    check("reset_rvalid", bus.rvalid, 0);
    check("reset_err",    bus.err, 0);
    check("reset_carry",  bus.carry, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) issue(6, i, 0);

    issue(3, 2, 'hB4); issue(6, 2, 0);
    issue(3, 0, 'hB4); issue(1, 0, 0); issue(6, 0, 0);
    issue(3, 1, 'hFF); issue(5, 1, 0); issue(6, 1, 0);
    issue(4, 0, 0);    issue(6, 1, 0);
    check("carry_after_clr", bus.carry, 0);
    issue(3, 3, 'h81); issue(2, 3, 0); issue(6, 3, 0);
    issue(3, 4, 'h00); issue(3, 0, 'h5A);
    issue(6, 5, 0);    issue(7, 0, 0);
    for (int i = 0; i < DEPTH; i++) issue(6, i, 0);

    // Reset during write-back of an INC on 0x10.
    issue(3, 0, 'h10);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b101; bus.cmd_addr = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("wb_ready_low", bus.cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", bus.cmd_ready, 1);
    check("async_reset_carry", bus.carry, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", bus.cmd_ready, 1);
    issue(6, 0, 0);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 7);
      if (op == 4 && $urandom_range(0, 2) != 0) op = 6;
      if ($urandom_range(0, 9) == 0) addr = $urandom_range(0, 7);
      else addr = $urandom_range(0, DEPTH - 1);
      issue(op, addr, $urandom_range(0, MODV - 1));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int i = 0; i < DEPTH; i++) issue(6, i, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
